rewrite_engine_multi: RTL and testbench

- Parametrised successor of the single-byte-lane header rewrite mux. Sits between the packet FIFO and the MAC/next stage.
- Applies up to N_RULES masked multi-byte rewrites per packet, each anchored to an absolute, L2, L3 or L4 offset, on a BEAT_BYTES-wide stream.
- Per-packet rules arrive as a descriptor via a valid/ready handshake. The descriptor can also drop the whole packet.
- Output is registered with full-throughput backpressure.

---
 rtl/rewrite_engine_multi.sv | 178 +++++++++++++++++
 tb/tb_rewrite_engine_multi.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rewrite_engine_multi.sv
// rewrite_engine_multi: masked multi-rule, multi-byte header rewrite on a byte stream, with per-packet descriptor and drop.
// Define REWRITE_ENGINE_STATS_EN to add the stat_pkts / stat_drops / stat_rw_bytes counters.
module rewrite_engine_multi #(
  parameter int BEAT_BYTES = 4,
  parameter int N_RULES = 4,
  parameter int RULE_BYTES = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic [8*BEAT_BYTES-1:0] in_data,
  input  logic [BEAT_BYTES-1:0] in_keep,
  input  logic in_last,
  output logic in_ready,
  output logic out_valid,
  output logic [8*BEAT_BYTES-1:0] out_data,
  output logic [BEAT_BYTES-1:0] out_keep,
  output logic out_last,
  input  logic out_ready,
  input  logic ctl_valid,
  output logic ctl_ready,
  input  logic ctl_drop,
  input  logic [N_RULES-1:0] ctl_rule_en,
  input  logic [2*N_RULES-1:0] ctl_rule_base,
  input  logic [16*N_RULES-1:0] ctl_rule_off,
  input  logic [4*N_RULES-1:0] ctl_rule_len,
  input  logic [8*RULE_BYTES*N_RULES-1:0] ctl_rule_val,
  input  logic [8*RULE_BYTES*N_RULES-1:0] ctl_rule_mask,
  input  logic [15:0] l2_offset,
  input  logic [15:0] l3_offset,
  input  logic [15:0] l4_offset
`ifdef REWRITE_ENGINE_STATS_EN
  ,
  output logic [31:0] stat_pkts,
  output logic [31:0] stat_drops,
  output logic [31:0] stat_rw_bytes
`endif
);
  localparam int DW = 8*BEAT_BYTES;
  localparam int VW = 8*RULE_BYTES*N_RULES;
  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
  state_t state_q, state_d;
  logic [15:0] byte_index_q, byte_index_d;
  logic [N_RULES-1:0] en_q, en_d;
  logic [16*N_RULES-1:0] start_q, start_d;
  logic [4*N_RULES-1:0] len_q, len_d;
  logic [VW-1:0] val_q, val_d, mask_q, mask_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DW-1:0] out_data_q, out_data_d, rw_data;
  logic [BEAT_BYTES-1:0] out_keep_q, out_keep_d;
  logic [15:0] anchor, k;
  logic [7:0] m, v;
  logic ctl_fire, in_fire, load;
`ifdef REWRITE_ENGINE_STATS_EN
  logic [BEAT_BYTES-1:0] rw_hit;
`endif
  assign ctl_ready = state_q == IDLE;
  assign in_ready = state_q == DROP || (state_q == PASS && (!out_valid_q || out_ready));
  assign ctl_fire = ctl_valid && ctl_ready;
  assign in_fire = in_valid && in_ready;
  assign load = in_fire && state_q == PASS;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_keep = out_keep_q;
  assign out_last = out_last_q;
  // Rules are visited in ascending order so the highest matching index overwrites last.
  always_comb begin
    rw_data = in_data;
    k = '0;
    m = '0;
    v = '0;
`ifdef REWRITE_ENGINE_STATS_EN
    rw_hit = '0;
`endif
    for (int j = 0; j < BEAT_BYTES; j++)
      for (int r = 0; r < N_RULES; r++) begin
        k = byte_index_q + 16'(j) - start_q[16*r +: 16];
        if (en_q[r] && in_keep[j] && k < {12'd0, len_q[4*r +: 4]})
          for (int b = 0; b < RULE_BYTES; b++)
            if (k == 16'(b)) begin
              m = mask_q[8*(r*RULE_BYTES+b) +: 8];
              v = val_q[8*(r*RULE_BYTES+b) +: 8];
              rw_data[8*j +: 8] = (in_data[8*j +: 8] & ~m) | (v & m);
`ifdef REWRITE_ENGINE_STATS_EN
              rw_hit[j] = |m;
`endif
            end
      end
  end
  always_comb begin
    state_d = state_q;
    byte_index_d = byte_index_q;
    en_d = en_q;
    start_d = start_q;
    len_d = len_q;
    val_d = val_q;
    mask_d = mask_q;
    anchor = '0;
    if (ctl_fire) begin
      state_d = ctl_drop ? DROP : PASS;
      byte_index_d = '0;
      en_d = ctl_rule_en;
      val_d = ctl_rule_val;
      mask_d = ctl_rule_mask;
      for (int r = 0; r < N_RULES; r++) begin
        anchor = ctl_rule_base[2*r +: 2] == 2'd0 ? 16'd0 :
                 ctl_rule_base[2*r +: 2] == 2'd1 ? l2_offset :
                 ctl_rule_base[2*r +: 2] == 2'd2 ? l3_offset : l4_offset;
        start_d[16*r +: 16] = anchor + ctl_rule_off[16*r +: 16];
        len_d[4*r +: 4] = ctl_rule_len[4*r +: 4] > 4'(RULE_BYTES) ? 4'(RULE_BYTES) : ctl_rule_len[4*r +: 4];
      end
    end
    if (in_fire) begin
      byte_index_d = byte_index_q + 16'(BEAT_BYTES);
      if (in_last) state_d = IDLE;
    end
    out_valid_d = load || (out_valid_q && !out_ready);
    out_data_d = load ? rw_data : out_data_q;
    out_keep_d = load ? in_keep : out_keep_q;
    out_last_d = load ? in_last : out_last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      byte_index_q <= '0;
      en_q <= '0;
      start_q <= '0;
      len_q <= '0;
      val_q <= '0;
      mask_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_index_q <= byte_index_d;
      en_q <= en_d;
      start_q <= start_d;
      len_q <= len_d;
      val_q <= val_d;
      mask_q <= mask_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_keep_q <= out_keep_d;
      out_last_q <= out_last_d;
    end
  end
`ifdef REWRITE_ENGINE_STATS_EN
  logic [31:0] pkts_q, pkts_d, drops_q, drops_d, rwb_q, rwb_d;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction
  always_comb begin
    pkts_d = sat_add(pkts_q, {31'd0, out_valid_q && out_ready && out_last_q});
    drops_d = sat_add(drops_q, {31'd0, in_fire && in_last && state_q == DROP});
    rwb_d = rwb_q;
    if (load)
      for (int j = 0; j < BEAT_BYTES; j++) rwb_d = sat_add(rwb_d, {31'd0, rw_hit[j]});
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pkts_q <= '0;
      drops_q <= '0;
      rwb_q <= '0;
    end else begin
      pkts_q <= pkts_d;
      drops_q <= drops_d;
      rwb_q <= rwb_d;
    end
  end
  assign stat_pkts = pkts_q;
  assign stat_drops = drops_q;
  assign stat_rw_bytes = rwb_q;
`endif
endmodule

// File: tb/tb_rewrite_engine_multi.sv
// tb_rewrite_engine_multi: scoreboard bench for rewrite_engine_multi using a whole-packet byte model.
module tb_rewrite_engine_multi;
  localparam int BB = 4;
  localparam int NR = 4;
  localparam int RB = 6;
  typedef struct {
    logic [8*BB-1:0] d;
    logic [BB-1:0] k;
    logic l;
    int acc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid, in_last, in_ready, out_valid, out_last, out_ready, ctl_valid, ctl_ready, ctl_drop;
  logic [8*BB-1:0] in_data, out_data;
  logic [BB-1:0] in_keep, out_keep;
  logic [NR-1:0] ctl_rule_en;
  logic [2*NR-1:0] ctl_rule_base;
  logic [16*NR-1:0] ctl_rule_off;
  logic [4*NR-1:0] ctl_rule_len;
  logic [8*RB*NR-1:0] ctl_rule_val, ctl_rule_mask;
  logic [15:0] l2_offset, l3_offset, l4_offset;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int bp_mode = 0;
  int bp_cnt = 0;
  int ob = 0;
  logic lat_on = 1'b0;
  logic stalled = 1'b0;
  exp_t sb[$];
  logic r_en[NR];
  logic [1:0] r_base[NR];
  logic [15:0] r_off[NR];
  logic [3:0] r_len[NR];
  logic [7:0] r_val[NR][RB];
  logic [7:0] r_mask[NR][RB];
  logic [15:0] l2, l3, l4;
  logic [7:0] pkt[512];
  logic [7:0] exp_pkt[512];
  logic [7:0] got[512];

  rewrite_engine_multi #(.BEAT_BYTES(BB), .N_RULES(NR), .RULE_BYTES(RB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep), .out_last(out_last), .out_ready(out_ready),
    .ctl_valid(ctl_valid), .ctl_ready(ctl_ready), .ctl_drop(ctl_drop),
    .ctl_rule_en(ctl_rule_en), .ctl_rule_base(ctl_rule_base), .ctl_rule_off(ctl_rule_off),
    .ctl_rule_len(ctl_rule_len), .ctl_rule_val(ctl_rule_val), .ctl_rule_mask(ctl_rule_mask),
    .l2_offset(l2_offset), .l3_offset(l3_offset), .l4_offset(l4_offset)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got_v, exp_v, cyc);
    end
  endtask

  task automatic clear_rules();
    for (int r = 0; r < NR; r++) begin
      r_en[r] = 1'b0; r_base[r] = 2'd0; r_off[r] = 16'd0; r_len[r] = 4'd0;
      for (int b = 0; b < RB; b++) begin r_val[r][b] = 8'h00; r_mask[r][b] = 8'h00; end
    end
    l2 = 16'd0; l3 = 16'd0; l4 = 16'd0;
  endtask

  task automatic gen_pkt(input int len);
    for (int i = 0; i < len; i++) pkt[i] = 8'($urandom);
  endtask

  task automatic model(input int len);
    logic [15:0] start, idx, anc;
    int lim;
    for (int i = 0; i < len; i++) exp_pkt[i] = pkt[i];
    for (int r = 0; r < NR; r++)
      if (r_en[r]) begin
        case (r_base[r])
          2'd0: anc = 16'd0;
          2'd1: anc = l2;
          2'd2: anc = l3;
          default: anc = l4;
        endcase
        start = anc + r_off[r];
        lim = r_len[r] > RB ? RB : int'(r_len[r]);
        for (int k = 0; k < lim; k++) begin
          idx = start + 16'(k);
          if (int'(idx) < len) exp_pkt[idx] = (pkt[idx] & ~r_mask[r][k]) | (r_val[r][k] & r_mask[r][k]);
        end
      end
  endtask

  task automatic send_desc(input logic drop);
    int n;
    @(negedge clk);
    ctl_valid = 1'b1;
    ctl_drop = drop;
    for (int r = 0; r < NR; r++) begin
      ctl_rule_en[r] = r_en[r];
      ctl_rule_base[2*r +: 2] = r_base[r];
      ctl_rule_off[16*r +: 16] = r_off[r];
      ctl_rule_len[4*r +: 4] = r_len[r];
      for (int b = 0; b < RB; b++) begin
        ctl_rule_val[8*(r*RB+b) +: 8] = r_val[r][b];
        ctl_rule_mask[8*(r*RB+b) +: 8] = r_mask[r][b];
      end
    end
    l2_offset = l2; l3_offset = l3; l4_offset = l4;
    #1;
    n = 0;
    while (!ctl_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!ctl_ready) check("tmo_ctl_ready", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    // Scramble the descriptor after acceptance; the latched copy must be used.
    ctl_valid = 1'b0;
    ctl_drop = ~drop;
    ctl_rule_en = NR'($urandom);
    for (int i = 0; i < NR*RB; i++) begin
      ctl_rule_val[8*i +: 8] = 8'($urandom);
      ctl_rule_mask[8*i +: 8] = 8'($urandom);
    end
    l2_offset = 16'($urandom); l3_offset = 16'($urandom); l4_offset = 16'($urandom);
  endtask

  task automatic send_pkt(input int len, input logic drop, input int stop_after);
    int nb, n, idx;
    exp_t e;
    model(len);
    nb = (len + BB - 1) / BB;
    for (int b = 0; b < nb; b++) begin
      if (b == stop_after) return;
      @(negedge clk);
      in_valid = 1'b1;
      in_last = (b == nb - 1);
      e.l = in_last;
      for (int j = 0; j < BB; j++) begin
        idx = b*BB + j;
        if (idx < len) begin
          in_data[8*j +: 8] = pkt[idx]; in_keep[j] = 1'b1; e.d[8*j +: 8] = exp_pkt[idx];
        end else begin
          in_data[8*j +: 8] = 8'($urandom); in_keep[j] = 1'b0; e.d[8*j +: 8] = in_data[8*j +: 8];
        end
      end
      e.k = in_keep;
      #1;
      if (!in_ready) stalled = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin @(negedge clk); #1; n++; end
      if (!in_ready) begin check("tmo_in_ready", 64'd0, 64'd1); return; end
      if (drop) begin
        check("drop_in_ready", 64'(in_ready), 64'd1);
        check("drop_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e.acc = cyc + 1;
        sb.push_back(e);
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0) check("tmo_drain", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  initial forever begin
    @(negedge clk);
    bp_cnt++;
    out_ready = bp_mode == 0 ? 1'b1 :
                bp_mode == 1 ? 1'(bp_cnt % 2) :
                (bp_cnt % 20 >= 10 && bp_cnt % 20 < 15) ? 1'b0 : 1'(bp_cnt % 2);
  end

  initial begin : monitor
    exp_t e;
    logic hold_v = 1'b0;
    logic [8*BB+BB:0] hold;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        hold_v = 1'b0;
        ob = 0;
      end else begin
        if (hold_v && out_valid) check("stall_hold", 64'({out_data, out_keep, out_last}), 64'(hold));
        if (hold_v && !out_valid) check("stall_lost", 64'd0, 64'd1);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) check("spurious_out", 64'd1, 64'd0);
          else begin
            e = sb.pop_front();
            check("beat_data", 64'(out_data), 64'(e.d));
            check("beat_keep", 64'(out_keep), 64'(e.k));
            check("beat_last", 64'(out_last), 64'(e.l));
            if (lat_on) check("latency", 64'(cyc), 64'(e.acc));
            for (int j = 0; j < BB; j++) if (out_keep[j]) got[ob + j] = out_data[8*j +: 8];
            ob = out_last ? 0 : ob + BB;
          end
        end
        hold_v = out_valid && !out_ready;
        hold = {out_data, out_keep, out_last};
      end
    end
  end

  initial begin
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_keep = '0;
    ctl_valid = 1'b0; ctl_drop = 1'b0; ctl_rule_en = '0; ctl_rule_base = '0; ctl_rule_off = '0;
    ctl_rule_len = '0; ctl_rule_val = '0; ctl_rule_mask = '0;
    l2_offset = '0; l3_offset = '0; l4_offset = '0;
    clear_rules();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_keep", 64'(out_keep), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_ctl_ready", 64'(ctl_ready), 64'd1);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;

    // Passthrough, 64 bytes, no rules.
    lat_on = 1'b1; stalled = 1'b0;
    gen_pkt(64);
    send_desc(1'b0);
    send_pkt(64, 1'b0, -1);
    drain();
    lat_on = 1'b0;
    check("pt_in_ready_low", 64'(stalled), 64'd0);

    // Destination MAC rewrite.
    clear_rules();
    r_en[0] = 1'b1; r_len[0] = 4'd6;
    r_val[0] = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int b = 0; b < RB; b++) r_mask[0][b] = 8'hFF;
    gen_pkt(30);
    send_desc(1'b0);
    send_pkt(30, 1'b0, -1);
    drain();
    check("mac_beat0", 64'({got[3], got[2], got[1], got[0]}), 64'h33221102);
    check("mac_b4_b5", 64'({got[5], got[4]}), 64'h5544);
    check("mac_b6", 64'(got[6]), 64'(pkt[6]));
    check("mac_b7", 64'(got[7]), 64'(pkt[7]));

    // DSCP masked rewrite at l3 + 1.
    clear_rules();
    l3 = 16'd14;
    r_en[1] = 1'b1; r_base[1] = 2'b10; r_off[1] = 16'd1; r_len[1] = 4'd1;
    r_val[1][0] = 8'hB8; r_mask[1][0] = 8'hFC;
    gen_pkt(40);
    pkt[15] = 8'h03;
    send_desc(1'b0);
    send_pkt(40, 1'b0, -1);
    drain();
    check("dscp_b15", 64'(got[15]), 64'hBB);

    // Overlap priority plus an l4-anchored rule whose length clamps to RULE_BYTES.
    clear_rules();
    l4 = 16'd34;
    r_en[0] = 1'b1; r_off[0] = 16'd18; r_len[0] = 4'd6;
    r_en[3] = 1'b1; r_off[3] = 16'd20; r_len[3] = 4'd2;
    r_en[1] = 1'b1; r_base[1] = 2'b11; r_len[1] = 4'd15;
    for (int b = 0; b < RB; b++) begin
      r_val[0][b] = 8'hAA; r_mask[0][b] = 8'hFF;
      r_val[3][b] = 8'h55; r_mask[3][b] = 8'hFF;
      r_val[1][b] = 8'($urandom); r_mask[1][b] = 8'($urandom);
    end
    gen_pkt(48);
    send_desc(1'b0);
    send_pkt(48, 1'b0, -1);
    drain();
    check("ovl_b20", 64'(got[20]), 64'h55);
    check("ovl_b18", 64'(got[18]), 64'hAA);
    check("clamp_b40", 64'(got[40]), 64'(pkt[40]));

    // Backpressure: toggling, then a 5-cycle stall window, with a beat-spanning l2 rule.
    clear_rules();
    l2 = 16'd7;
    r_en[2] = 1'b1; r_base[2] = 2'b01; r_off[2] = 16'd3; r_len[2] = 4'd4;
    for (int b = 0; b < RB; b++) begin r_val[2][b] = 8'($urandom); r_mask[2][b] = 8'($urandom); end
    bp_mode = 1;
    gen_pkt(64);
    send_desc(1'b0);
    send_pkt(64, 1'b0, -1);
    drain();
    bp_mode = 2;
    gen_pkt(62);
    send_desc(1'b0);
    send_pkt(62, 1'b0, -1);
    drain();
    bp_mode = 0;

    // Dropped packet.
    gen_pkt(36);
    send_desc(1'b1);
    send_pkt(36, 1'b1, -1);
    #1;
    check("drop_idle", 64'(ctl_ready), 64'd1);
    check("drop_no_out", 64'(out_valid), 64'd0);

    // Reset during beat 3 of 8.
    clear_rules();
    gen_pkt(32);
    send_desc(1'b0);
    send_pkt(32, 1'b0, 3);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_out_valid", 64'(out_valid), 64'd0);
    check("rstmid_ctl_ready", 64'(ctl_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    sb.delete();
    r_en[0] = 1'b1; r_off[0] = 16'd2; r_len[0] = 4'd3;
    for (int b = 0; b < RB; b++) begin r_val[0][b] = 8'hC0 + 8'(b); r_mask[0][b] = 8'hFF; end
    gen_pkt(32);
    send_desc(1'b0);
    send_pkt(32, 1'b0, -1);
    drain();
    check("rstmid_b2", 64'(got[2]), 64'hC0);
    check("rstmid_b5", 64'(got[5]), 64'(pkt[5]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
